// File: rtl/mips_pipe_pkg.sv
// Shared pipeline types and constants for the MIPS-style fetch/decode boundary.
// The IF/ID record is defined here so the ID stage can reuse the same layout.
package mips_pipe_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT  = 32'h0000_3000;
    localparam logic [XLEN-1:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc4;
        logic            valid;
    } if_id_t;

    // Pipeline bubble: a NOP that downstream stages must treat as empty.
    function automatic if_id_t if_id_bubble(input logic [XLEN-1:0] nop_instr);
        if_id_t b;
        b.instr = nop_instr;
        b.pc4   = '0;
        b.valid = 1'b0;
        return b;
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush inserts a bubble, enable loads, otherwise holds.
// Flush takes priority over enable so a squashed fetch can never be captured.
module if_id_reg
    import mips_pipe_pkg::*;
#(
    parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic   clk,
    input  logic   rst_ni,
    input  logic   en_i,
    input  logic   flush_i,
    input  if_id_t d_i,
    output if_id_t q_o
);

    if_id_t q_q;

    // NOTE: sequential state is written with non-blocking assignments only, so
    // every register samples its pre-edge inputs regardless of block ordering.
    always_ff @(posedge clk) begin
        if (!rst_ni) begin
            q_q <= if_id_bubble(NOP_INSTR);
        end else if (flush_i) begin
            q_q <= if_id_bubble(NOP_INSTR);
        end else if (en_i) begin
            q_q <= d_i;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/if_stage_ctrl.sv
// Instruction-fetch stage: PC register and redirect mux, IF/ID register, and
// stall/flush performance counters. Redirects come from branches resolved in ID.
module if_stage_ctrl
    import mips_pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT,
    parameter int          CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    output logic [31:0]      imem_addr,
    input  logic [31:0]      imem_rdata,
    input  logic             hz_stall_lu,
    input  logic             hz_stall_br,
    input  logic             irwr_if,
    input  logic             irwr_id,
    input  logic             br_taken,
    input  logic [31:0]      br_target,
    input  logic             jump,
    input  logic [31:0]      jump_target,
    input  logic             cnt_clr,
    output logic [31:0]      pc,
    output logic [31:0]      if_id_instr,
    output logic [31:0]      if_id_pc4,
    output logic             if_id_valid,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    logic [31:0]      pc_q, pc_d, pc_plus4;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             hold, pc_en, ifid_en, redirect, any_hold;
    if_id_t           if_id_d, if_id_q;

    // NOTE: every signal driven here gets a default first, so no path through
    // the block leaves a value unassigned and no latch is inferred.
    always_comb begin
        hold     = hz_stall_lu | hz_stall_br;
        pc_en    = ~hold & irwr_if;
        ifid_en  = ~hold & irwr_id;
        // A stalled ID instruction has stale operands, so its branch is ignored.
        redirect = (br_taken | jump) & pc_en & ifid_en;
        any_hold = hold | ~irwr_if | ~irwr_id;
        pc_plus4 = pc_q + 32'd4;

        pc_d = pc_q;
        if (redirect) begin
            pc_d = jump ? jump_target : br_target;
        end else if (pc_en) begin
            pc_d = pc_plus4;
        end

        if_id_d.instr = imem_rdata;
        if_id_d.pc4   = pc_plus4;
        if_id_d.valid = 1'b1;

        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (cnt_clr) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (any_hold) stall_cnt_d = stall_cnt_q + CNT_W'(1);
            if (redirect) flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q        <= RESET_PC;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            pc_q        <= pc_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk     (clk),
        .rst_ni  (rst),
        .en_i    (ifid_en),
        .flush_i (redirect),
        .d_i     (if_id_d),
        .q_o     (if_id_q)
    );

    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign if_id_instr = if_id_q.instr;
    assign if_id_pc4   = if_id_q.pc4;
    assign if_id_valid = if_id_q.valid;
    assign stall_cnt   = stall_cnt_q;
    assign flush_cnt   = flush_cnt_q;

endmodule
